// File: rtl/alu_issue_queue.sv
// Integer/branch ALU issue queue: tracks operand readiness and issues the oldest ready micro-op.
// Latency: select in cycle N, registered issue beat visible in N+1 (enqueue-to-issue minimum 2 cycles).
// Backpressure: enq_ready drops at DEPTH entries; the issue beat holds while alu_valid is low.
module alu_issue_queue #(
  parameter int DEPTH     = 8,
  parameter int ROB_W     = 6,
  parameter int PREG_W    = 7,
  parameter int PAYLOAD_W = 96,
  parameter int WK_PORTS  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enq_valid,
  output logic                          enq_ready,
  input  logic [PAYLOAD_W-1:0]          enq_payload,
  input  logic [ROB_W:0]                enq_rob_idx,
  input  logic [PREG_W-1:0]             enq_rd,
  input  logic [PREG_W-1:0]             enq_rs1,
  input  logic [PREG_W-1:0]             enq_rs2,
  input  logic                          enq_rs1_rdy,
  input  logic                          enq_rs2_rdy,
  input  logic [WK_PORTS-1:0]           wk_en,
  input  logic [WK_PORTS*PREG_W-1:0]    wk_preg,
  output logic                          issue_en,
  output logic [PAYLOAD_W-1:0]          issue_payload,
  output logic [ROB_W:0]                issue_rob_idx,
  output logic [PREG_W-1:0]             issue_rd,
  output logic [PREG_W-1:0]             issue_rs1,
  output logic [PREG_W-1:0]             issue_rs2,
  input  logic                          alu_valid,
  input  logic                          redirect_en,
  input  logic [ROB_W:0]                redirect_rob_idx,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int RI_W  = ROB_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // a is older than b; the dir bit flips each time the ROB pointer wraps
  function automatic logic is_older(input logic [RI_W-1:0] a, input logic [RI_W-1:0] b);
    if (a[ROB_W] == b[ROB_W]) return a[ROB_W-1:0] < b[ROB_W-1:0];
    else                      return a[ROB_W-1:0] > b[ROB_W-1:0];
  endfunction

  function automatic logic is_younger(input logic [RI_W-1:0] a, input logic [RI_W-1:0] b);
    return !is_older(a, b) && (a != b);
  endfunction

  // true when any active wakeup port broadcasts this tag
  function automatic logic wk_hit(input logic [PREG_W-1:0] tag,
                                  input logic [WK_PORTS-1:0] en,
                                  input logic [WK_PORTS*PREG_W-1:0] pregs);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WK_PORTS; k++) begin
      if (en[k] && (pregs[k*PREG_W +: PREG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // entry storage
  logic [DEPTH-1:0]     r_vld;
  logic [DEPTH-1:0]     r_r1;
  logic [DEPTH-1:0]     r_r2;
  logic [PAYLOAD_W-1:0] r_pay [DEPTH];
  logic [RI_W-1:0]      r_rob [DEPTH];
  logic [PREG_W-1:0]    r_rd  [DEPTH];
  logic [PREG_W-1:0]    r_rs1 [DEPTH];
  logic [PREG_W-1:0]    r_rs2 [DEPTH];
  logic [CNT_W-1:0]     r_count;

  // issue register
  logic                 r_iss_en;
  logic [PAYLOAD_W-1:0] r_iss_pay;
  logic [RI_W-1:0]      r_iss_rob;
  logic [PREG_W-1:0]    r_iss_rd;
  logic [PREG_W-1:0]    r_iss_rs1;
  logic [PREG_W-1:0]    r_iss_rs2;

  logic [DEPTH-1:0]     w_kill;
  logic [DEPTH-1:0]     w_cand;
  logic [CNT_W-1:0]     w_nkill;
  logic                 w_found;
  logic [IDX_W-1:0]     w_sel_idx;
  logic [RI_W-1:0]      w_best_rob;
  logic [IDX_W-1:0]     w_enq_idx;
  logic                 w_iss_kill;
  logic                 w_adv;
  logic                 w_free;
  logic                 w_enq_fire;
  logic                 w_enq_drop;
  logic                 w_enq_wr;
  logic                 w_enq_r1;
  logic                 w_enq_r2;

  // per-entry flush and select-candidate flags; killed entries are never picked
  always_comb begin
    w_kill  = '0;
    w_cand  = '0;
    w_nkill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_kill[i] = redirect_en & r_vld[i] & is_younger(r_rob[i], redirect_rob_idx);
      w_cand[i] = r_vld[i] & r_r1[i] & r_r2[i] & ~w_kill[i];
      w_nkill   = w_nkill + CNT_W'(w_kill[i]);
    end
  end

  // oldest-ready pick; robIdx values are unique so there is never a tie
  always_comb begin
    w_found    = 1'b0;
    w_sel_idx  = '0;
    w_best_rob = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_cand[i] && (!w_found || is_older(r_rob[i], w_best_rob))) begin
        w_found    = 1'b1;
        w_sel_idx  = IDX_W'(i);
        w_best_rob = r_rob[i];
      end
    end
  end

  // lowest-index free slot, scanned from the top so the lowest wins
  always_comb begin
    w_enq_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_vld[i]) w_enq_idx = IDX_W'(i);
    end
  end

  // A flushed issue beat blocks selection this cycle so the register empties
  // even when the ALU is accepting; otherwise the stage advances on accept or when empty.
  assign w_iss_kill = redirect_en & r_iss_en & is_younger(r_iss_rob, redirect_rob_idx);
  assign w_adv      = (alu_valid | ~r_iss_en) & ~w_iss_kill;
  assign w_free     = w_adv & w_found;

  // enq_ready looks only at the registered count, so a same-cycle free does not help
  assign enq_ready  = (r_count < DEPTH_C);
  assign w_enq_fire = enq_valid & enq_ready;
  assign w_enq_drop = redirect_en & is_younger(enq_rob_idx, redirect_rob_idx);
  assign w_enq_wr   = w_enq_fire & ~w_enq_drop;
  assign w_enq_r1   = enq_rs1_rdy | wk_hit(enq_rs1, wk_en, wk_preg);
  assign w_enq_r2   = enq_rs2_rdy | wk_hit(enq_rs2, wk_en, wk_preg);

  // entry state: free on issue or flush, write on enqueue, collect wakeups otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
      r_r1  <= '0;
      r_r2  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pay[i] <= '0;
        r_rob[i] <= '0;
        r_rd[i]  <= '0;
        r_rs1[i] <= '0;
        r_rs2[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_kill[i] || (w_free && (w_sel_idx == IDX_W'(i)))) begin
          r_vld[i] <= 1'b0;
          r_r1[i]  <= 1'b0;
          r_r2[i]  <= 1'b0;
        end else if (w_enq_wr && !r_vld[i] && (w_enq_idx == IDX_W'(i))) begin
          r_vld[i] <= 1'b1;
          r_r1[i]  <= w_enq_r1;
          r_r2[i]  <= w_enq_r2;
          r_pay[i] <= enq_payload;
          r_rob[i] <= enq_rob_idx;
          r_rd[i]  <= enq_rd;
          r_rs1[i] <= enq_rs1;
          r_rs2[i] <= enq_rs2;
        end else if (r_vld[i]) begin
          r_r1[i]  <= r_r1[i] | wk_hit(r_rs1[i], wk_en, wk_preg);
          r_r2[i]  <= r_r2[i] | wk_hit(r_rs2[i], wk_en, wk_preg);
        end
      end
    end
  end

  // occupancy: enqueue adds, issue and flush remove
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_count <= '0;
    else      r_count <= r_count + CNT_W'(w_enq_wr) - CNT_W'(w_free) - w_nkill;
  end

  // issue beat: flush clears it, advance loads the winner or empties it, otherwise hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_iss_en  <= 1'b0;
      r_iss_pay <= '0;
      r_iss_rob <= '0;
      r_iss_rd  <= '0;
      r_iss_rs1 <= '0;
      r_iss_rs2 <= '0;
    end else if (w_iss_kill) begin
      r_iss_en  <= 1'b0;
    end else if (w_adv) begin
      r_iss_en  <= w_found;
      if (w_found) begin
        r_iss_pay <= r_pay[w_sel_idx];
        r_iss_rob <= r_rob[w_sel_idx];
        r_iss_rd  <= r_rd[w_sel_idx];
        r_iss_rs1 <= r_rs1[w_sel_idx];
        r_iss_rs2 <= r_rs2[w_sel_idx];
      end
    end
  end

  assign issue_en      = r_iss_en;
  assign issue_payload = r_iss_pay;
  assign issue_rob_idx = r_iss_rob;
  assign issue_rd      = r_iss_rd;
  assign issue_rs1     = r_iss_rs1;
  assign issue_rs2     = r_iss_rs2;
  assign count         = r_count;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Bench for alu_issue_queue: directed stimulus with an expected-issue scoreboard.
// Latency: issue beats are compared at the falling edge of the cycle the ALU accepts them.
// Backpressure: alu_valid is driven by the bench to exercise hold and drain.
module tb_alu_issue_queue;

  logic         clk;
  logic         rst;
  logic         enq_valid;
  logic         enq_ready;
  logic [95:0]  enq_payload;
  logic [6:0]   enq_rob_idx;
  logic [6:0]   enq_rd;
  logic [6:0]   enq_rs1;
  logic [6:0]   enq_rs2;
  logic         enq_rs1_rdy;
  logic         enq_rs2_rdy;
  logic [3:0]   wk_en;
  logic [27:0]  wk_preg;
  logic         issue_en;
  logic [95:0]  issue_payload;
  logic [6:0]   issue_rob_idx;
  logic [6:0]   issue_rd;
  logic [6:0]   issue_rs1;
  logic [6:0]   issue_rs2;
  logic         alu_valid;
  logic         redirect_en;
  logic [6:0]   redirect_rob_idx;
  logic [3:0]   count;

  int           n_chk;
  int           n_pass;
  logic [6:0]   exp_q [$];
  logic [6:0]   mon_e;

  alu_issue_queue dut (
    .clk              (clk),
    .rst              (rst),
    .enq_valid        (enq_valid),
    .enq_ready        (enq_ready),
    .enq_payload      (enq_payload),
    .enq_rob_idx      (enq_rob_idx),
    .enq_rd           (enq_rd),
    .enq_rs1          (enq_rs1),
    .enq_rs2          (enq_rs2),
    .enq_rs1_rdy      (enq_rs1_rdy),
    .enq_rs2_rdy      (enq_rs2_rdy),
    .wk_en            (wk_en),
    .wk_preg          (wk_preg),
    .issue_en         (issue_en),
    .issue_payload    (issue_payload),
    .issue_rob_idx    (issue_rob_idx),
    .issue_rd         (issue_rd),
    .issue_rs1        (issue_rs1),
    .issue_rs2        (issue_rs2),
    .alu_valid        (alu_valid),
    .redirect_en      (redirect_en),
    .redirect_rob_idx (redirect_rob_idx),
    .count            (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [95:0] pay_of(input logic [6:0] r);
    return {r, 25'h1ABCDEF, r, 25'h0F0F0F0, r, 25'h1234567};
  endfunction

  function automatic logic [6:0] rd_of(input logic [6:0] r);
    return r ^ 7'h55;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_enq(input logic [6:0] rob, input logic [6:0] rs1, input logic rdy1,
                           input logic [6:0] rs2, input logic rdy2);
    enq_valid   = 1'b1;
    enq_rob_idx = rob;
    enq_payload = pay_of(rob);
    enq_rd      = rd_of(rob);
    enq_rs1     = rs1;
    enq_rs1_rdy = rdy1;
    enq_rs2     = rs2;
    enq_rs2_rdy = rdy2;
  endtask

  task automatic idle_enq;
    enq_valid   = 1'b0;
    enq_rs1_rdy = 1'b0;
    enq_rs2_rdy = 1'b0;
  endtask

  task automatic set_wk(input logic [3:0] en, input logic [6:0] t0, input logic [6:0] t1,
                        input logic [6:0] t2, input logic [6:0] t3);
    wk_en   = en;
    wk_preg = {t3, t2, t1, t0};
  endtask

  task automatic drain(input int max_cycles);
    for (int i = 0; i < max_cycles && (exp_q.size() > 0 || issue_en); i++) tick;
    chk("drain_scoreboard_empty", 128'(exp_q.size()), 128'd0);
    chk("drain_count_zero", 128'(count), 128'd0);
  endtask

  // scoreboard: every beat the ALU accepts must be the next expected micro-op
  always @(negedge clk) begin
    if (rst && issue_en && alu_valid) begin
      if (exp_q.size() == 0) begin
        chk("issue_with_empty_scoreboard", 128'(exp_q.size()), 128'd1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_issue_rob", 128'(issue_rob_idx), 128'(mon_e));
        chk("sb_issue_payload", 128'(issue_payload), 128'(pay_of(mon_e)));
        chk("sb_issue_rd", 128'(issue_rd), 128'(rd_of(mon_e)));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b0;
    idle_enq;
    enq_payload = '0; enq_rob_idx = '0; enq_rd = '0; enq_rs1 = '0; enq_rs2 = '0;
    set_wk(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
    alu_valid = 1'b0;
    redirect_en = 1'b0;
    redirect_rob_idx = '0;

    // reset state
    #2;
    chk("rst_issue_en", 128'(issue_en), 128'd0);
    chk("rst_issue_rob", 128'(issue_rob_idx), 128'd0);
    chk("rst_issue_payload", 128'(issue_payload), 128'd0);
    chk("rst_issue_rd", 128'(issue_rd), 128'd0);
    chk("rst_issue_rs", 128'({issue_rs1, issue_rs2}), 128'd0);
    chk("rst_count", 128'(count), 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick;
    chk("enq_ready_after_reset", 128'(enq_ready), 128'd1);

    // single op, sources ready: issue two cycles after enqueue
    alu_valid = 1'b1;
    drive_enq(7'd3, 7'd40, 1'b1, 7'd41, 1'b1);
    exp_q.push_back(7'd3);
    tick;
    idle_enq;
    chk("t1_count_after_enq", 128'(count), 128'd1);
    chk("t1_no_issue_yet", 128'(issue_en), 128'd0);
    tick;
    chk("t1_issue_en", 128'(issue_en), 128'd1);
    chk("t1_issue_rob", 128'(issue_rob_idx), 128'd3);
    chk("t1_count_zero", 128'(count), 128'd0);
    tick;
    chk("t1_issue_en_falls", 128'(issue_en), 128'd0);

    // back-to-back 5, 4, 6
    drive_enq(7'd5, 7'd42, 1'b1, 7'd43, 1'b1); exp_q.push_back(7'd5);
    tick;
    drive_enq(7'd4, 7'd44, 1'b1, 7'd45, 1'b1); exp_q.push_back(7'd4);
    tick;
    drive_enq(7'd6, 7'd46, 1'b1, 7'd47, 1'b1); exp_q.push_back(7'd6);
    chk("t2_first_rob5", 128'(issue_rob_idx), 128'd5);
    tick;
    idle_enq;
    chk("t2_second_rob4", 128'(issue_rob_idx), 128'd4);
    tick;
    chk("t2_third_rob6", 128'(issue_rob_idx), 128'd6);
    tick;
    chk("t2_idle_en", 128'(issue_en), 128'd0);
    chk("t2_count_zero", 128'(count), 128'd0);

    // wakeup in the enqueue cycle is captured
    drive_enq(7'd2, 7'd17, 1'b0, 7'd30, 1'b1);
    set_wk(4'b0001, 7'd17, 7'd0, 7'd0, 7'd0);
    exp_q.push_back(7'd2);
    tick;
    idle_enq;
    set_wk(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
    chk("t3a_count", 128'(count), 128'd1);
    tick;
    chk("t3a_issue_en", 128'(issue_en), 128'd1);
    chk("t3a_issue_rob", 128'(issue_rob_idx), 128'd2);
    chk("t3a_issue_rs1", 128'(issue_rs1), 128'd17);
    tick;

    // late wakeup, with a non-matching broadcast first
    drive_enq(7'd7, 7'd17, 1'b0, 7'd31, 1'b1);
    exp_q.push_back(7'd7);
    tick;
    idle_enq;
    set_wk(4'b0010, 7'd0, 7'd18, 7'd0, 7'd0);
    tick;
    set_wk(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
    chk("t3b_wait1", 128'(issue_en), 128'd0);
    tick;
    chk("t3b_wait2", 128'(issue_en), 128'd0);
    set_wk(4'b0100, 7'd0, 7'd0, 7'd17, 7'd0);
    tick;
    set_wk(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
    chk("t3b_wait3", 128'(issue_en), 128'd0);
    tick;
    chk("t3b_issue_en", 128'(issue_en), 128'd1);
    chk("t3b_issue_rob", 128'(issue_rob_idx), 128'd7);
    tick;

    // fill, refuse when full, wake all, hold while the ALU stalls
    alu_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_enq(7'(20 + i), 7'(60 + i), 1'b0, 7'(100 + i), 1'b1);
      exp_q.push_back(7'(20 + i));
      tick;
    end
    drive_enq(7'd28, 7'd90, 1'b1, 7'd91, 1'b1);
    chk("t4_full_enq_ready", 128'(enq_ready), 128'd0);
    chk("t4_full_count", 128'(count), 128'd8);
    tick;
    idle_enq;
    chk("t4_refused_count", 128'(count), 128'd8);
    set_wk(4'b1111, 7'd60, 7'd61, 7'd62, 7'd63);
    tick;
    set_wk(4'b1111, 7'd64, 7'd65, 7'd66, 7'd67);
    tick;
    set_wk(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
    for (int h = 0; h < 4; h++) begin
      chk("t4_hold_en", 128'(issue_en), 128'd1);
      chk("t4_hold_rob", 128'(issue_rob_idx), 128'd20);
      chk("t4_hold_payload", 128'(issue_payload), 128'(pay_of(7'd20)));
      chk("t4_hold_count", 128'(count), 128'd7);
      if (h < 3) tick;
    end
    alu_valid = 1'b1;
    tick;
    chk("t4_next_rob21", 128'(issue_rob_idx), 128'd21);
    tick;
    chk("t4_next_rob22", 128'(issue_rob_idx), 128'd22);
    drain(30);

    // ROB wrap: dir-0 62, 63 are older than dir-1 1, 2
    drive_enq(7'd66, 7'd10, 1'b0, 7'd50, 1'b1);
    tick;
    drive_enq(7'd63, 7'd11, 1'b0, 7'd51, 1'b1);
    tick;
    drive_enq(7'd65, 7'd12, 1'b0, 7'd52, 1'b1);
    tick;
    drive_enq(7'd62, 7'd13, 1'b0, 7'd53, 1'b1);
    tick;
    idle_enq;
    set_wk(4'b1111, 7'd10, 7'd11, 7'd12, 7'd13);
    exp_q.push_back(7'd62);
    exp_q.push_back(7'd63);
    exp_q.push_back(7'd65);
    exp_q.push_back(7'd66);
    chk("t5_nothing_ready", 128'(issue_en), 128'd0);
    tick;
    set_wk(4'b0000, 7'd0, 7'd0, 7'd0, 7'd0);
    chk("t5_count", 128'(count), 128'd4);
    tick;
    chk("t5_rob62", 128'(issue_rob_idx), 128'd62);
    tick;
    chk("t5_rob63", 128'(issue_rob_idx), 128'd63);
    tick;
    chk("t5_rob65", 128'(issue_rob_idx), 128'd65);
    tick;
    chk("t5_rob66", 128'(issue_rob_idx), 128'd66);
    drain(10);

    // redirect at 11 kills entry 12, the held beat 13 and a same-cycle enqueue of 14
    alu_valid = 1'b0;
    drive_enq(7'd13, 7'd1, 1'b1, 7'd2, 1'b1);
    tick;
    drive_enq(7'd10, 7'd3, 1'b1, 7'd4, 1'b1);
    tick;
    drive_enq(7'd11, 7'd5, 1'b1, 7'd6, 1'b1);
    chk("t6_held_en", 128'(issue_en), 128'd1);
    chk("t6_held_rob13", 128'(issue_rob_idx), 128'd13);
    tick;
    drive_enq(7'd12, 7'd7, 1'b1, 7'd8, 1'b1);
    tick;
    chk("t6_pre_count", 128'(count), 128'd3);
    chk("t6_pre_rob13", 128'(issue_rob_idx), 128'd13);
    drive_enq(7'd14, 7'd9, 1'b1, 7'd10, 1'b1);
    redirect_en = 1'b1;
    redirect_rob_idx = 7'd11;
    exp_q.push_back(7'd10);
    exp_q.push_back(7'd11);
    tick;
    idle_enq;
    redirect_en = 1'b0;
    chk("t6_killed_en", 128'(issue_en), 128'd0);
    chk("t6_post_count", 128'(count), 128'd2);
    alu_valid = 1'b1;
    tick;
    chk("t6_issue_rob10", 128'(issue_rob_idx), 128'd10);
    tick;
    chk("t6_issue_rob11", 128'(issue_rob_idx), 128'd11);
    tick;
    chk("t6_final_en", 128'(issue_en), 128'd0);
    chk("t6_final_count", 128'(count), 128'd0);

    tick;
    chk("end_scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
